keypad_scan_ctrl: RTL

Scan controller and event queue for the 4x4 matrix keypad that supplies Tetris move commands. It drives one-cold column strobes, synchronises and debounces the active-low rows, and detects press, hold and release. Debounced key events, including auto-repeat for held keys, are queued in a small FIFO and handed to the game logic over a valid/ready handshake.

---
 rtl/keypad_scan_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-cold column strobes, synchronised/debounced rows,
// press/hold/release tracking with auto-repeat, and a show-ahead event FIFO.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_repeat,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int TICK_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_MAX = (DEBOUNCE > REPEAT_DELAY)
                         ? ((DEBOUNCE > REPEAT_RATE) ? DEBOUNCE : REPEAT_RATE)
                         : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_C     = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0]  DELAY_C   = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]  RATE_C    = CNT_W'(REPEAT_RATE);
  localparam logic [PTR_W:0]    FULL_C    = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  logic [3:0]        rows_meta, rows_sync, rows_q, rows_q_n;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  state_t            state, state_n;
  logic [3:0]        cols_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic              rep_phase, rep_phase_n;
  logic              push, push_rep;
  logic [3:0]        rows_low;
  logic              single;
  logic [1:0]        row_idx, col_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta <= '1;
      rows_sync <= '1;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  always_comb begin
    rows_low = ~rows_sync;
    single   = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
    row_idx  = '0;
    col_idx  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows_sync[i]) row_idx = 2'(i);
      if (!cols[i])      col_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_SCAN;
      cols      <= 4'b0111;
      cnt       <= '0;
      rows_q    <= '1;
      rep_phase <= 1'b0;
    end else begin
      state     <= state_n;
      cols      <= cols_n;
      cnt       <= cnt_n;
      rows_q    <= rows_q_n;
      rep_phase <= rep_phase_n;
    end
  end

  // Repeat schedule: cnt restarts after every repeat push and rep_phase selects
  // whether the next target is the initial delay or the repeat rate.
  always_comb begin
    state_n     = state;
    cols_n      = cols;
    cnt_n       = cnt;
    rows_q_n    = rows_q;
    rep_phase_n = rep_phase;
    push        = 1'b0;
    push_rep    = 1'b0;
    cnt_inc     = cnt + CNT_W'(1);
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (single) begin
            rows_q_n = rows_sync;
            if (DEBOUNCE == 1) begin
              push        = 1'b1;
              cnt_n       = '0;
              rep_phase_n = 1'b0;
              state_n     = S_HELD;
            end else begin
              cnt_n   = CNT_W'(1);
              state_n = S_DEBOUNCE;
            end
          end else begin
            cols_n = {cols[0], cols[3:1]};
          end
        end
        S_DEBOUNCE: begin
          if (rows_sync == rows_q) begin
            if (cnt_inc == DEB_C) begin
              push        = 1'b1;
              cnt_n       = '0;
              rep_phase_n = 1'b0;
              state_n     = S_HELD;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = S_SCAN;
          end
        end
        S_HELD: begin
          if (rows_sync == rows_q) begin
            if (cnt_inc == (rep_phase ? RATE_C : DELAY_C)) begin
              push        = 1'b1;
              push_rep    = 1'b1;
              cnt_n       = '0;
              rep_phase_n = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else if (DEBOUNCE == 1) begin
            state_n = S_SCAN;
            cols_n  = {cols[0], cols[3:1]};
          end else begin
            cnt_n   = CNT_W'(1);
            state_n = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (single) begin
            cnt_n       = '0;
            rep_phase_n = 1'b0;
            state_n     = S_HELD;
          end else if (cnt_inc == DEB_C) begin
            state_n = S_SCAN;
            cols_n  = {cols[0], cols[3:1]};
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = S_SCAN;
      endcase
    end
  end

  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_n;
  logic             full, pop, wr_en;

  assign full  = (count == FULL_C);
  assign pop   = key_valid & key_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    count_n = count;
    case ({wr_en, pop})
      2'b10:   count_n = count + (PTR_W+1)'(1);
      2'b01:   count_n = count - (PTR_W+1)'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {push_rep, row_idx, col_idx};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_n;
      key_valid <= (count_n != '0);
      overflow  <= push & full & ~pop;
    end
  end

  assign {key_repeat, key_code} = mem[rd_ptr];

endmodule
